// File: rtl/ascii_hex_stream_decoder.sv
// Streams ASCII hex characters in over valid/ready and packs NUM_BYTES*2 digits into one word.
// Word is presented on a registered valid/ready output; malformed input raises a one-cycle error pulse.
module ascii_hex_stream_decoder #(
  parameter int NUM_BYTES   = 2,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit ALLOW_LOWER = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_BYTES*8-1:0] out_data,
  output logic                   err_valid,
  output logic [1:0]             err_code
);

  localparam int ND = NUM_BYTES * 2;
  localparam int W  = NUM_BYTES * 8;
  localparam int CW = $clog2(ND + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   out_q, out_d;
  logic           in_ready_q, in_ready_d;
  logic           err_v_q, err_v_d;
  logic [1:0]     err_c_q, err_c_d;

  logic           is_dig, is_sep, in_xfer;
  logic [3:0]     nib;
  logic [W-1:0]   acc_ins;

  always_comb begin
    is_dig = 1'b0;
    nib    = 4'h0;
    if (in_char >= 8'h30 && in_char <= 8'h39) begin
      is_dig = 1'b1;
      nib    = in_char[3:0];
    end else if (in_char >= 8'h41 && in_char <= 8'h46) begin
      is_dig = 1'b1;
      nib    = in_char[3:0] + 4'd9;
    end else if (ALLOW_LOWER && in_char >= 8'h61 && in_char <= 8'h66) begin
      is_dig = 1'b1;
      nib    = in_char[3:0] + 4'd9;
    end
    is_sep = (in_char == 8'h20) || (in_char == 8'h2C) ||
             (in_char == 8'h0D) || (in_char == 8'h0A);
  end

  // Accumulator value with the current character's nibble merged in.
  always_comb begin
    acc_ins = acc_q;
    if (MSB_FIRST) begin
      acc_ins = {acc_q[W-5:0], nib};
    end else begin
      for (int k = 0; k < ND; k++) begin
        if (cnt_q == CW'(k)) acc_ins[4*k +: 4] = nib;
      end
    end
  end

  assign in_xfer = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    err_v_d = 1'b0;
    err_c_d = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          if (is_dig) begin
            acc_d   = acc_ins;
            cnt_d   = CW'(1);
            state_d = S_COLLECT;
          end else if (!is_sep) begin
            err_v_d = 1'b1;
            err_c_d = 2'b01;
          end
        end
      end
      S_COLLECT: begin
        if (in_xfer) begin
          if (is_dig) begin
            if (cnt_q == CW'(ND - 1)) begin
              out_d   = acc_ins;
              acc_d   = '0;
              cnt_d   = CW'(ND);
              state_d = S_HOLD;
            end else begin
              acc_d = acc_ins;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // Any non-digit aborts the partial word; separator means it was short.
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
            err_v_d = 1'b1;
            err_c_d = is_sep ? 2'b10 : 2'b01;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        acc_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    in_ready_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      in_ready_q <= 1'b1;
      err_v_q    <= 1'b0;
      err_c_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      in_ready_q <= in_ready_d;
      err_v_q    <= err_v_d;
      err_c_q    <= err_c_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = out_q;
  assign err_valid = err_v_q;
  assign err_code  = err_c_q;

endmodule

// File: tb/tb_ascii_hex_stream_decoder.sv
// Directed bench for ascii_hex_stream_decoder: three instances (default, LSB-first, uppercase-only)
// share one input stream; expected values are hand-computed constants.
module tb_ascii_hex_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        out_ready;

  logic        m_in_ready, m_out_valid, m_err_valid;
  logic [15:0] m_out_data;
  logic [1:0]  m_err_code;
  logic        l_in_ready, l_out_valid, l_err_valid;
  logic [15:0] l_out_data;
  logic [1:0]  l_err_code;
  logic        n_in_ready, n_out_valid, n_err_valid;
  logic [15:0] n_out_data;
  logic [1:0]  n_err_code;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ascii_hex_stream_decoder #(.NUM_BYTES(2), .MSB_FIRST(1'b1), .ALLOW_LOWER(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_char(in_char),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
    .err_valid(m_err_valid), .err_code(m_err_code)
  );

  ascii_hex_stream_decoder #(.NUM_BYTES(2), .MSB_FIRST(1'b0), .ALLOW_LOWER(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_char(in_char),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
    .err_valid(l_err_valid), .err_code(l_err_code)
  );

  ascii_hex_stream_decoder #(.NUM_BYTES(2), .MSB_FIRST(1'b1), .ALLOW_LOWER(1'b0)) u_nolow (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_char(in_char),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .err_valid(n_err_valid), .err_code(n_err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents one character for exactly one cycle; returns 1 time unit after the accepting edge.
  task automatic put(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, m_in_ready},  32'd1);
    check("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, m_out_data},  32'd0);
    check("rst_err_valid", {31'd0, m_err_valid}, 32'd0);
    check("rst_err_code",  {30'd0, m_err_code},  32'd0);
    rst = 1'b0;
    step();

    // "1A2F" MSB-first and LSB-first
    put("1"); put("A"); put("2");
    check("msb_no_early_valid", {31'd0, m_out_valid}, 32'd0);
    put("F");
    check("msb_out_valid",  {31'd0, m_out_valid}, 32'd1);
    check("msb_out_data",   {16'd0, m_out_data},  32'h1A2F);
    check("msb_in_ready_hold", {31'd0, m_in_ready}, 32'd0);
    check("lsb_out_data",   {16'd0, l_out_data},  32'hF2A1);
    step();
    check("msb_valid_one_cycle", {31'd0, m_out_valid}, 32'd0);
    check("msb_in_ready_back",   {31'd0, m_in_ready},  32'd1);

    // "beef": accepted with lowercase, back-to-back errors without
    put("b");
    check("nolow_err_b_v",  {31'd0, n_err_valid}, 32'd1);
    check("nolow_err_b_c",  {30'd0, n_err_code},  32'd1);
    check("low_no_err",     {31'd0, m_err_valid}, 32'd0);
    put("e");
    check("nolow_err_e_v",  {31'd0, n_err_valid}, 32'd1);
    put("e");
    check("nolow_err_e2_v", {31'd0, n_err_valid}, 32'd1);
    put("f");
    check("nolow_err_f_c",  {30'd0, n_err_code},  32'd1);
    check("nolow_no_valid", {31'd0, n_out_valid}, 32'd0);
    check("low_out_valid",  {31'd0, m_out_valid}, 32'd1);
    check("low_out_data",   {16'd0, m_out_data},  32'hBEEF);
    check("low_lsb_data",   {16'd0, l_out_data},  32'hFEEB);
    step();
    check("nolow_err_drop", {31'd0, n_err_valid}, 32'd0);

    // Backpressure with "00FF"; a character offered during HOLD must not be taken
    out_ready = 1'b0;
    put("0"); put("0"); put("F"); put("F");
    in_valid = 1'b1;
    in_char  = "7";
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, m_out_valid}, 32'd1);
      check("bp_out_data",  {16'd0, m_out_data},  32'h00FF);
      check("bp_in_ready",  {31'd0, m_in_ready},  32'd0);
      step();
    end
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    step();
    check("bp_release_valid",    {31'd0, m_out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, m_in_ready},  32'd1);
    check("bp_no_err",           {31'd0, m_err_valid}, 32'd0);

    // " 12\n34AB": leading space ignored, LF ends a short word
    put(" ");
    check("sep_idle_no_err", {31'd0, m_err_valid}, 32'd0);
    put("1"); put("2"); put(8'h0A);
    check("short_err_v", {31'd0, m_err_valid}, 32'd1);
    check("short_err_c", {30'd0, m_err_code},  32'd2);
    put("3");
    check("short_err_pulse", {31'd0, m_err_valid}, 32'd0);
    put("4"); put("A"); put("B");
    check("sep_out_valid", {31'd0, m_out_valid}, 32'd1);
    check("sep_out_data",  {16'd0, m_out_data},  32'h34AB);
    check("sep_lsb_data",  {16'd0, l_out_data},  32'hBA43);
    step();

    // "1G" then a clean word proves the count restarted
    put("1"); put("G");
    check("bad_err_v", {31'd0, m_err_valid}, 32'd1);
    check("bad_err_c", {30'd0, m_err_code},  32'd1);
    put("C"); put("A"); put("F"); put("E");
    check("after_bad_data", {16'd0, m_out_data}, 32'hCAFE);
    step();

    // Reset mid-word: partial word lost without an error
    put("9"); put("A");
    rst = 1'b1;
    #1;
    check("mid_rst_err_valid", {31'd0, m_err_valid}, 32'd0);
    check("mid_rst_out_data",  {16'd0, m_out_data},  32'd0);
    check("mid_rst_in_ready",  {31'd0, m_in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, m_out_valid}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_err_valid", {31'd0, m_err_valid}, 32'd0);
    put("0"); put("0"); put("0"); put("1");
    check("post_rst_valid", {31'd0, m_out_valid}, 32'd1);
    check("post_rst_data",  {16'd0, m_out_data},  32'h0001);
    check("post_rst_lsb",   {16'd0, l_out_data},  32'h1000);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii_hex_stream_decoder.md
# ascii_hex_stream_decoder

Streaming successor to the combinational ASCII-to-hex translator. It accepts one ASCII character per cycle over a valid/ready handshake and accumulates `NUM_BYTES*2` hex digits into one binary word. It emits the word on a registered valid/ready output and reports malformed input, with separator handling and configurable digit order. It sits between the UART receive path and the command/register decoders.

## Interface
- `NUM_BYTES`, default 2: bytes per output word; the word is `NUM_BYTES*2` hex digits. Legal values 1..8.
- `MSB_FIRST`, default 1:
  - 1: the first received digit becomes the most significant nibble.
  - 0: the first digit becomes nibble 0 (`data[3:0]`).
- `ALLOW_LOWER`, default 1: 1 accepts 'a'-'f' as 10-15; 0 treats them as invalid.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_char` is valid.
- `in_ready` output 1: the block accepts `in_char` this cycle.
- `in_char` input 8: ASCII character.
- `out_valid` output 1: `out_data` holds a complete word.
- `out_ready` input 1: downstream accepts the word.
- `out_data` output `NUM_BYTES*8`: decoded word.
- `err_valid` output 1: one-cycle error pulse.
- `err_code` output 2: 01 bad character, 10 short word; valid only while `err_valid` is high.

## Operation
- **Transfers.** An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **Character classes:**
  - Digit: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), and 'a'-'f' (0x61-0x66) only if `ALLOW_LOWER`=1.
  - Separator: space 0x20, ',' 0x2C, CR 0x0D, LF 0x0A.
  - Everything else is invalid.
- **States:**
  - IDLE: count = 0.
  - COLLECT: 0 < count < `NUM_BYTES*2`.
  - HOLD: word pending, `out_valid`=1.
- **IDLE:**
  - Digit: store the nibble, count = 1, go to COLLECT. With `NUM_BYTES*2` = 2 the second digit completes the word as described under COLLECT.
  - Separator: ignored.
  - Invalid: err 01, stay in IDLE.
- **COLLECT:**
  - Digit: store the nibble and increment count. On the `NUM_BYTES*2`-th digit, load `out_data` and go to HOLD.
  - Separator: discard the partial word, err 10, go to IDLE.
  - Invalid: discard the partial word, err 01, go to IDLE.
- **HOLD:** `in_ready`=0. On an output transfer, go to IDLE and clear count.
- **`in_ready`** = 1 in IDLE and COLLECT, 0 in HOLD. It is registered and must not depend combinationally on `out_ready`.
- **Nibble placement:**
  - `MSB_FIRST`=1: the shift register shifts left by 4 and inserts each new nibble at [3:0].
  - `MSB_FIRST`=0: digit k (0-based) is written to nibble k.
- **Accumulator.** It is cleared on entry to IDLE, so stale nibbles never appear in `out_data`.
- **`out_data`** is held stable while `out_valid`=1 and `out_ready`=0.
- **Digit counter width** is `$clog2(NUM_BYTES*2+1)`. Count never exceeds `NUM_BYTES*2`; no wrap-around is possible.

## Timing
- **Reset values:**
  - Asserting `rst` at any time forces IDLE, count = 0, accumulator = 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `err_valid`=0, `err_code`=00.
  - A partial word is lost silently, with no error.
- **Output latency.** `out_valid` rises on the clock edge that accepts the final digit, i.e. it is visible the cycle after that transfer.
- **Error latency.** `err_valid` and `err_code` are registered. They pulse for exactly one cycle, the cycle after the offending transfer.
- **Throughput.** With `out_ready` held high and one character per cycle, a word is produced every `NUM_BYTES*2+1` cycles, because HOLD lasts one cycle.
- **Simultaneous events.** In HOLD no input is accepted, so output and input transfers never coincide.
- **Error pulses.** An error pulse can never coincide with a new `out_valid` rise.
- **Back-to-back errors.** Consecutive invalid characters produce consecutive single-cycle pulses, one per character.

## Test plan
- **MSB-first word.** `MSB_FIRST`=1, `NUM_BYTES`=2, stream "1A2F", `out_ready`=1 → `out_data`=0x1A2F, `out_valid` high 1 cycle, then `in_ready` returns to 1.
- **LSB-first word.** `MSB_FIRST`=0, stream "1A2F" → `out_data`=0xF2A1.
- **Lowercase rejected.** `ALLOW_LOWER`=0, stream "beef" → err 01 on 'b'. Further errors follow on 'e','e','f', which are also invalid. No `out_valid`.
- **Lowercase accepted.** `ALLOW_LOWER`=1, stream "beef" → `out_data`=0xBEEF.
- **Backpressure.**
  - Stream "00FF" with `out_ready`=0 for 5 cycles → `out_valid` stays 1, `out_data` is stable at 0x00FF, and `in_ready`=0 throughout.
  - Then raise `out_ready` → the transfer occurs and `in_ready`=1 the next cycle.
- **Separators and short words.**
  - Stream " 12\n34AB" → the leading space is ignored, err 10 on LF, then `out_data`=0x34AB.
  - Stream "1G" → err 01 on 'G', count returns to 0.
- **Reset mid-word.** Send "9A" then assert `rst` → all outputs take their reset values with no `err_valid`. A following stream "0001" → `out_data`=0x0001.
